// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
// Module   : lbp_hist
// Brief    : Local Binary Pattern histogram. Counts incoming 8-bit LBP codes
//            into saturating per-bin counters, then streams every bin out
//            over a valid/ready handshake and raises a sticky done flag.
// Options  : LBP_HIST_UNIFORM_EN - when defined, codes are folded into 59
//            uniform-LBP bins (58 uniform codes in ascending order, then one
//            shared bin for all non-uniform codes). Undefined: 256 bins,
//            one per code.
// Revision : 1.0 - initial release
// ============================================================================
module lbp_hist #(
  parameter int BIN_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  input  logic             hist_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [BIN_W-1:0] hist_count,
  output logic             hist_done
);

`ifdef LBP_HIST_UNIFORM_EN
  localparam int NB = 59;
`else
  localparam int NB = 256;
`endif
  localparam int IDX_W = $clog2(NB);
  localparam logic [BIN_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic [BIN_W-1:0] cnt_q [NB];
  logic [BIN_W-1:0] cnt_d [NB];
  logic [IDX_W-1:0] acc_idx;

`ifdef LBP_HIST_UNIFORM_EN
  // Number of circular 0/1 transitions around the 8-bit code.
  function automatic int transitions(input logic [7:0] code);
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      if (code[i] != code[(i + 1) % 8]) t++;
    end
    return t;
  endfunction

  // Uniform codes get their rank among all uniform codes; others share bin 58.
  function automatic logic [7:0] uniform_bin(input logic [7:0] code);
    logic [7:0] rank;
    rank = 8'd0;
    if (transitions(code) > 2) return 8'd58;
    for (int c = 0; c < 256; c++) begin
      if (c < int'(code) && transitions(8'(c)) <= 2) rank++;
    end
    return rank;
  endfunction

  // Constant code-to-bin table, fully resolved at elaboration.
  logic [IDX_W-1:0] map_lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_map
    assign map_lut[g] = IDX_W'(uniform_bin(8'(g)));
  end
  assign acc_idx = map_lut[lbp_data];
`else
  assign acc_idx = lbp_data;
`endif

  // Next state: accumulate codes, then walk the bins under the handshake.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    for (int i = 0; i < NB; i++) cnt_d[i] = cnt_q[i];
    unique case (state_q)
      ST_ACCUM: begin
        // Counters are flops, so same-code updates on consecutive cycles
        // always see the previous increment.
        if (lbp_valid && (cnt_q[acc_idx] != CNT_MAX)) begin
          cnt_d[acc_idx] = cnt_q[acc_idx] + 1'b1;
        end
        if (lbp_finish) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (hist_ready) begin
          if (bin_q == LAST_BIN) state_d = ST_DONE;
          else                   bin_d   = bin_q + 1'b1;
        end
      end
      default: begin
        // DONE is terminal until reset.
      end
    endcase
  end

  // State, bin pointer and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ACCUM;
      bin_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hist_valid = (state_q == ST_DUMP);
  assign hist_done  = (state_q == ST_DONE);
  assign hist_bin   = 8'(bin_q);
  assign hist_count = hist_valid ? cnt_q[bin_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbp_hist
// Brief    : Directed, table-driven bench for lbp_hist (default BIN_W and a
//            BIN_W=4 instance for counter saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_hist;

`ifdef LBP_HIST_UNIFORM_EN
  localparam int NB      = 59;
  localparam int RST_BIN = 40;
  localparam int FF_BIN  = 57;
`else
  localparam int NB      = 256;
  localparam int RST_BIN = 100;
  localparam int FF_BIN  = 255;
`endif

  typedef struct {
    logic       val;
    logic [7:0] code;
    logic       fin;
  } in_t;

  typedef struct {
    int bin;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, lbp_valid, lbp_finish, hist_ready;
  logic [7:0]  lbp_data;
  logic        hist_valid, hist_done;
  logic [7:0]  hist_bin;
  logic [14:0] hist_count;

  logic        c_reset, c_valid, c_finish, c_ready;
  logic [7:0]  c_data;
  logic        c_hvalid, c_done;
  logic [7:0]  c_bin;
  logic [3:0]  c_count;

  int total = 0;
  int bad   = 0;

  in_t  in_q[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  lbp_hist #(.BIN_W(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .lbp_finish (lbp_finish),
    .hist_ready (hist_ready),
    .hist_valid (hist_valid),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_done  (hist_done)
  );

  lbp_hist #(.BIN_W(4)) dut4 (
    .clk        (clk),
    .reset      (c_reset),
    .lbp_valid  (c_valid),
    .lbp_data   (c_data),
    .lbp_finish (c_finish),
    .hist_ready (c_ready),
    .hist_valid (c_hvalid),
    .hist_bin   (c_bin),
    .hist_count (c_count),
    .hist_done  (c_done)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_finish = 1'b0;
    lbp_data   = 8'h00;
    hist_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic feed();
    foreach (in_q[i]) begin
      lbp_valid  = in_q[i].val;
      lbp_data   = in_q[i].code;
      lbp_finish = in_q[i].fin;
      step();
    end
    lbp_valid  = 1'b0;
    lbp_finish = 1'b0;
  endtask

  // Walk all bins, checking each against exp_q (unlisted bins expect 0).
  task automatic dump(input int hold_bin, input int rst_bin, input bit intrude);
    int e[256];
    for (int i = 0; i < 256; i++) e[i] = 0;
    foreach (exp_q[i]) e[exp_q[i].bin] = exp_q[i].cnt;
    if (intrude) begin
      lbp_valid  = 1'b1;
      lbp_data   = 8'hFE;
      lbp_finish = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      check($sformatf("valid[%0d]", b), int'(hist_valid), 1);
      check($sformatf("bin[%0d]", b), int'(hist_bin), b);
      check($sformatf("count[%0d]", b), int'(hist_count), e[b]);
      if (b == rst_bin) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_valid", int'(hist_valid), 0);
        check("rst_done", int'(hist_done), 0);
        check("rst_bin", int'(hist_bin), 0);
        check("rst_count", int'(hist_count), 0);
        hist_ready = 1'b0;
        return;
      end
      if (b == hold_bin) begin
        hist_ready = 1'b0;
        repeat (10) begin
          step();
          check("hold_bin", int'(hist_bin), b);
          check("hold_count", int'(hist_count), e[b]);
          check("hold_valid", int'(hist_valid), 1);
        end
      end
      hist_ready = 1'b1;
      step();
    end
    hist_ready = 1'b0;
    check("end_done", int'(hist_done), 1);
    check("end_valid", int'(hist_valid), 0);
    lbp_valid  = 1'b1;
    lbp_finish = 1'b1;
    hist_ready = 1'b1;
    repeat (3) step();
    lbp_valid  = 1'b0;
    lbp_finish = 1'b0;
    hist_ready = 1'b0;
    check("sticky_done", int'(hist_done), 1);
    check("sticky_valid", int'(hist_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    c_reset  = 1'b0;
    c_valid  = 1'b0;
    c_finish = 1'b0;
    c_ready  = 1'b0;
    c_data   = 8'h00;
    do_reset();

    // Reset state
    check("reset_valid", int'(hist_valid), 0);
    check("reset_bin", int'(hist_bin), 0);
    check("reset_count", int'(hist_count), 0);
    check("reset_done", int'(hist_done), 0);

    // Five zeros, separate finish; hist_ready held high during ACCUM
    hist_ready = 1'b1;
    in_q  = '{'{1'b1, 8'h00, 1'b0}, '{1'b1, 8'h00, 1'b0}, '{1'b1, 8'h00, 1'b0},
              '{1'b1, 8'h00, 1'b0}, '{1'b1, 8'h00, 1'b0}, '{1'b0, 8'h00, 1'b1}};
    exp_q = '{'{0, 5}};
    feed();
    dump(-1, -1, 1'b0);

    // Mixed codes with finish on the last valid; stall at bin 3; inputs
    // driven during DUMP must be ignored
    do_reset();
`ifdef LBP_HIST_UNIFORM_EN
    in_q  = '{'{1'b1, 8'h00, 1'b0}, '{1'b1, 8'h01, 1'b0}, '{1'b1, 8'hFF, 1'b0},
              '{1'b1, 8'h05, 1'b1}};
    exp_q = '{'{0, 1}, '{1, 1}, '{57, 1}, '{58, 1}};
`else
    in_q  = '{'{1'b1, 8'hA5, 1'b0}, '{1'b1, 8'h3C, 1'b0}, '{1'b1, 8'hA5, 1'b0},
              '{1'b1, 8'hFF, 1'b0}, '{1'b1, 8'h12, 1'b0}, '{1'b1, 8'h12, 1'b1}};
    exp_q = '{'{8'hA5, 2}, '{8'h3C, 1}, '{8'hFF, 1}, '{8'h12, 2}};
`endif
    feed();
    dump(3, -1, 1'b1);

    // Reset mid-DUMP abandons the histogram; a fresh dump shows all zeros
    do_reset();
    in_q  = '{'{1'b1, 8'h00, 1'b0}, '{1'b0, 8'h00, 1'b1}};
    exp_q = '{'{0, 1}};
    feed();
    dump(-1, RST_BIN, 1'b0);
    in_q  = '{'{1'b0, 8'h00, 1'b1}};
    exp_q = {};
    feed();
    dump(-1, -1, 1'b0);

    // Saturation on the 4-bit instance
    step();
    c_reset = 1'b1;
    c_valid = 1'b1;
    c_data  = 8'hFF;
    repeat (20) step();
    c_valid  = 1'b0;
    c_finish = 1'b1;
    step();
    c_finish = 1'b0;
    check("sat_bin0_count", int'(c_count), 0);
    c_ready = 1'b1;
    found   = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (c_hvalid && (int'(c_bin) == FF_BIN)) found = 1'b1;
      else step();
    end
    check("sat_reached", int'(found), 1);
    if (found) check("sat_count", int'(c_count), 15);
    c_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
